lock_key_loader: RTL and testbench

- Delivers the unlock key to a logic-locked combinational core with XOR/XNOR key gates on internal nets (e.g. the c432 locked netlist, KEY_WIDTH=10).
- Receives the key as a serial frame (key bits, then check bits), verifies the check field, and commits the key to a parallel register driving the key gates.
- Until a verified key is committed, drives a decoy key.
- Counts failed attempts and enters permanent lockout after MAX_FAIL consecutive failures.

---
 rtl/lock_key_loader.sv | 176 +++++++++++++++++
 tb/tb_lock_key_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_key_loader.sv
`default_nettype none
// ============================================================================
// Module   : lock_key_loader
// Function : Serial key loader with check-field verification and lockout
//            for the key gates of a logic-locked core.
// Revision : 1.0
// ============================================================================
module lock_key_loader #(
  parameter int                  KEY_WIDTH = 10,
  parameter int                  CHK_WIDTH = 4,
  parameter int                  MAX_FAIL  = 3,
  parameter logic [KEY_WIDTH-1:0] DECOY_KEY = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_start,
  input  logic                            sdata,
  input  logic                            svalid,
  output logic [KEY_WIDTH-1:0]            key_out,
  output logic                            key_valid,
  output logic                            busy,
  output logic                            err,
  output logic                            lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int CNT_W = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
  localparam int FCW   = $clog2(MAX_FAIL + 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_WIDTH - 1);
  localparam logic [CNT_W-1:0] CHK_LAST = CNT_W'(CHK_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [FCW-1:0]   FAIL_MAX = FCW'(MAX_FAIL);
  localparam logic [FCW-1:0]   FAIL_ONE = FCW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_KEY = 3'd1,
    S_SHIFT_CHK = 3'd2,
    S_CHECK     = 3'd3,
    S_LOADED    = 3'd4,
    S_LOCKOUT   = 3'd5
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [KEY_WIDTH-1:0]   r_shift, w_shift_nxt;
  logic [CHK_WIDTH-1:0]   r_chk,   w_chk_nxt;
  logic [CNT_W-1:0]       r_cnt,   w_cnt_nxt;
  logic [KEY_WIDTH-1:0]   r_key,   w_key_nxt;
  logic                   r_kv,    w_kv_nxt;
  logic                   r_err,   w_err_nxt;
  logic [FCW-1:0]         r_fail,  w_fail_nxt;
  logic [FCW-1:0]         w_fail_inc;
  logic [CHK_WIDTH-1:0]   w_exp_chk;

  // Check bit j folds every key bit whose index is congruent to j mod CHK_WIDTH.
  always_comb begin
    w_exp_chk = '0;
    for (int i = 0; i < KEY_WIDTH; i += CHK_WIDTH) begin
      w_exp_chk = w_exp_chk ^ CHK_WIDTH'(r_shift >> i);
    end
  end

  assign w_fail_inc = (r_fail < FAIL_MAX) ? (r_fail + FAIL_ONE) : r_fail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_chk   <= '0;
      r_cnt   <= '0;
      r_key   <= DECOY_KEY;
      r_kv    <= 1'b0;
      r_err   <= 1'b0;
      r_fail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_chk   <= w_chk_nxt;
      r_cnt   <= w_cnt_nxt;
      r_key   <= w_key_nxt;
      r_kv    <= w_kv_nxt;
      r_err   <= w_err_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_chk_nxt   = r_chk;
    w_cnt_nxt   = r_cnt;
    w_key_nxt   = r_key;
    w_kv_nxt    = r_kv;
    w_err_nxt   = r_err;
    w_fail_nxt  = r_fail;

    // Bits enter at the MSB and shift down, so after the full field the
    // first (LSB-first) bit sits at position 0.
    case (r_state)
      S_IDLE, S_LOADED: begin
        if (load_start) begin
          w_state_nxt = S_SHIFT_KEY;
          w_shift_nxt = '0;
          w_chk_nxt   = '0;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end
      S_SHIFT_KEY: begin
        if (load_start) begin
          w_shift_nxt = '0;
          w_chk_nxt   = '0;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
        end else if (svalid) begin
          w_shift_nxt = (KEY_WIDTH'(sdata) << (KEY_WIDTH - 1)) | (r_shift >> 1);
          if (r_cnt == KEY_LAST) begin
            w_state_nxt = S_SHIFT_CHK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      S_SHIFT_CHK: begin
        if (load_start) begin
          w_state_nxt = S_SHIFT_KEY;
          w_shift_nxt = '0;
          w_chk_nxt   = '0;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
        end else if (svalid) begin
          w_chk_nxt = (CHK_WIDTH'(sdata) << (CHK_WIDTH - 1)) | (r_chk >> 1);
          if (r_cnt == CHK_LAST) begin
            w_state_nxt = S_CHECK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      S_CHECK: begin
        if (r_chk == w_exp_chk) begin
          w_key_nxt   = r_shift;
          w_kv_nxt    = 1'b1;
          w_fail_nxt  = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_LOADED;
        end else begin
          w_key_nxt   = DECOY_KEY;
          w_kv_nxt    = 1'b0;
          w_err_nxt   = 1'b1;
          w_fail_nxt  = w_fail_inc;
          w_state_nxt = (w_fail_inc == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
        end
      end
      S_LOCKOUT: begin
        w_key_nxt = DECOY_KEY;
        w_kv_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign key_out   = r_key;
  assign key_valid = r_kv;
  assign err       = r_err;
  assign fail_cnt  = r_fail;
  assign busy      = (r_state == S_SHIFT_KEY) || (r_state == S_SHIFT_CHK) ||
                     (r_state == S_CHECK);
  assign lockout   = (r_state == S_LOCKOUT);

endmodule
`default_nettype wire

// File: tb/tb_lock_key_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_key_loader
// Function : Scoreboard bench for lock_key_loader: frames, stalls, aborts,
//            failures, lockout and resets.
// Revision : 1.0
// ============================================================================
module tb_lock_key_loader;

  localparam int KW = 10;
  localparam int CW = 4;
  localparam int MF = 3;
  localparam logic [KW-1:0] DECOY = 10'h000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          sdata = 1'b0;
  logic          svalid = 1'b0;
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic          busy;
  logic          err;
  logic          lockout;
  logic [1:0]    fail_cnt;

  lock_key_loader #(
    .KEY_WIDTH (KW),
    .CHK_WIDTH (CW),
    .MAX_FAIL  (MF),
    .DECOY_KEY (DECOY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .sdata      (sdata),
    .svalid     (svalid),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .busy       (busy),
    .err        (err),
    .lockout    (lockout),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [KW-1:0] key;
    logic          kv;
    logic          err;
    logic [1:0]    fail;
    logic          lock;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [KW-1:0] m_key  = DECOY;
  logic          m_kv   = 1'b0;
  logic          m_err  = 1'b0;
  logic [1:0]    m_fail = 2'd0;
  logic          m_lock = 1'b0;

  function automatic logic [CW-1:0] calc_chk(input logic [KW-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < KW; i++) c[i % CW] = c[i % CW] ^ k[i];
    return c;
  endfunction

  task automatic model_reset();
    m_key = DECOY; m_kv = 1'b0; m_err = 1'b0; m_fail = 2'd0; m_lock = 1'b0;
  endtask

  // Drives one frame; after the last bit, one CHECK cycle then the result.
  task automatic send_frame(input logic [KW-1:0] k, input logic [CW-1:0] c,
                            input int gap_at, input int gap_len);
    logic [KW+CW-1:0] bits;
    logic [KW-1:0]    prev_key;
    logic             prev_kv;
    logic             exp_err_mid;
    exp_t             e;
    bits        = {c, k};
    prev_key    = m_key;
    prev_kv     = m_kv;
    exp_err_mid = m_lock ? m_err : 1'b0;
    @(negedge clk);
    load_start = 1'b1; svalid = 1'b0;
    for (int i = 0; i < KW + CW; i++) begin
      @(negedge clk);
      load_start = 1'b0;
      n_vec++;
      if (busy !== !m_lock || key_out !== prev_key || key_valid !== prev_kv ||
          err !== exp_err_mid) begin
        n_err++;
        $display("FAIL frame_mid bit%0d: busy=%b key=%h kv=%b err=%b, want busy=%b key=%h kv=%b err=%b",
                 i, busy, key_out, key_valid, err, !m_lock, prev_key, prev_kv, exp_err_mid);
      end
      sdata = bits[i]; svalid = 1'b1;
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          svalid = 1'b0; sdata = ~bits[i + 1];
        end
      end
    end
    @(negedge clk);
    svalid = 1'b0; sdata = 1'b1;
    n_vec++;
    if (busy !== !m_lock || key_out !== prev_key || key_valid !== prev_kv) begin
      n_err++;
      $display("FAIL check_cycle: busy=%b key=%h kv=%b, want busy=%b key=%h kv=%b",
               busy, key_out, key_valid, !m_lock, prev_key, prev_kv);
    end
    if (!m_lock) begin
      if (c == calc_chk(k)) begin
        m_key = k; m_kv = 1'b1; m_err = 1'b0; m_fail = 2'd0;
      end else begin
        m_key = DECOY; m_kv = 1'b0; m_err = 1'b1;
        if (m_fail < 2'(MF)) m_fail = m_fail + 2'd1;
        if (m_fail == 2'(MF)) m_lock = 1'b1;
      end
    end
    sb.push_back('{key: m_key, kv: m_kv, err: m_err, fail: m_fail, lock: m_lock});
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (key_out !== e.key || key_valid !== e.kv || err !== e.err ||
        fail_cnt !== e.fail || lockout !== e.lock || busy !== 1'b0) begin
      n_err++;
      $display("FAIL result: key=%h kv=%b err=%b fail=%0d lock=%b busy=%b, want key=%h kv=%b err=%b fail=%0d lock=%b busy=0",
               key_out, key_valid, err, fail_cnt, lockout, busy,
               e.key, e.kv, e.err, e.fail, e.lock);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_vec++;
    if (key_out !== DECOY || key_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
        lockout !== 1'b0 || fail_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL reset: key=%h kv=%b busy=%b err=%b lock=%b fail=%0d, want all zero",
               key_out, key_valid, busy, err, lockout, fail_cnt);
    end
  endtask

  task automatic test_good_frame();
    send_frame(10'h003, 4'b0011, -1, 0);
  endtask

  task automatic test_bad_then_good();
    send_frame(10'h003, 4'b0000, -1, 0);
    send_frame(10'h003, 4'b0011, -1, 0);
  endtask

  task automatic test_stall();
    send_frame(10'h003, 4'b0011, 4, 3);
  endtask

  task automatic test_patterns();
    logic [KW-1:0] k;
    send_frame(10'h2A5, calc_chk(10'h2A5), -1, 0);
    send_frame(10'h3FF, calc_chk(10'h3FF), 9, 2);
    for (int n = 0; n < 3; n++) begin
      k = KW'($urandom);
      send_frame(k, calc_chk(k), int'($urandom_range(0, 12)), int'($urandom_range(0, 2)));
    end
    send_frame(10'h003, 4'b0011, -1, 0);
  endtask

  task automatic test_abort();
    @(negedge clk);
    load_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load_start = 1'b0; sdata = 1'b1; svalid = 1'b1;
      n_vec++;
      if (key_out !== 10'h003 || key_valid !== 1'b1 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL abort_hold bit%0d: key=%h kv=%b busy=%b, want key=003 kv=1 busy=1",
                 i, key_out, key_valid, busy);
      end
    end
    send_frame(10'h003, 4'b0011, -1, 0);
  endtask

  task automatic test_midframe_reset();
    @(negedge clk);
    load_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load_start = 1'b0; sdata = i[0]; svalid = 1'b1;
    end
    @(negedge clk);
    svalid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_vec++;
    if (key_out !== DECOY || key_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
        lockout !== 1'b0 || fail_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL midframe_reset: key=%h kv=%b busy=%b err=%b lock=%b fail=%0d, want all zero",
               key_out, key_valid, busy, err, lockout, fail_cnt);
    end
    send_frame(10'h003, 4'b0011, -1, 0);
  endtask

  task automatic test_lockout();
    for (int n = 0; n < MF; n++) send_frame(10'h155, calc_chk(10'h155) ^ 4'b0001, -1, 0);
    send_frame(10'h003, 4'b0011, -1, 0);
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    n_vec++;
    if (lockout !== 1'b1 || busy !== 1'b0 || key_out !== DECOY || fail_cnt !== 2'd3) begin
      n_err++;
      $display("FAIL lockout_hold: lock=%b busy=%b key=%h fail=%0d, want lock=1 busy=0 key=000 fail=3",
               lockout, busy, key_out, fail_cnt);
    end
    test_reset();
    send_frame(10'h003, 4'b0011, -1, 0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_then_good();
    test_stall();
    test_patterns();
    test_abort();
    test_midframe_reset();
    test_lockout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
